// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the load/store unit.
// One transaction in flight; LSU wins ties unless IF has been starved STARVE_LIMIT times.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 64,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned WDT_WIDTH    = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_resp_valid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic                  lsu_wen,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    input  logic [WDT_WIDTH-1:0]  lsu_wdt_op,
    output logic                  lsu_resp_valid,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wen,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [WDT_WIDTH-1:0]  mem_wdt_op,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned CNT_WIDTH = 8;
    localparam logic [WDT_WIDTH-1:0] WDT_DOUBLE = {1'b1, {(WDT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } stateT;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  wen;
        logic [DATA_WIDTH-1:0] wdata;
        logic [WDT_WIDTH-1:0]  wdtOp;
    } memReqT;

    stateT                state;
    stateT                stateNext;
    memReqT               reqQ;
    logic                 ownerLsu;
    logic [CNT_WIDTH-1:0] starveCnt;
    logic                 forceIf;
    logic                 grantLsu;
    logic                 grantIf;

    // Grant selection, next state and all combinational handshake outputs
    always_comb begin
        stateNext      = state;
        forceIf        = (starveCnt == CNT_WIDTH'(STARVE_LIMIT));
        grantLsu       = lsu_req_valid & ~(forceIf & if_req_valid);
        grantIf        = if_req_valid & ~grantLsu;
        if_req_ready   = 1'b0;
        lsu_req_ready  = 1'b0;
        mem_req_valid  = 1'b0;
        if_resp_valid  = 1'b0;
        lsu_resp_valid = 1'b0;
        if_rdata       = '0;
        lsu_rdata      = '0;

        case (state)
            IDLE: begin
                if_req_ready  = grantIf;
                lsu_req_ready = grantLsu;
                if (grantIf || grantLsu) begin
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    if_resp_valid  = ~ownerLsu;
                    lsu_resp_valid = ownerLsu;
                    if_rdata       = ownerLsu ? '0 : mem_rdata;
                    lsu_rdata      = ownerLsu ? mem_rdata : '0;
                    stateNext      = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Request latch, owner and IF starvation tracking; only IDLE can change them
    always_ff @(posedge clk) begin
        if (rst) begin
            reqQ      <= '0;
            ownerLsu  <= 1'b0;
            starveCnt <= '0;
        end else if (state == IDLE) begin
            if (grantLsu) begin
                reqQ.addr  <= lsu_addr;
                reqQ.wen   <= lsu_wen;
                reqQ.wdata <= lsu_wdata;
                reqQ.wdtOp <= lsu_wdt_op;
                ownerLsu   <= 1'b1;
            end else if (grantIf) begin
                reqQ.addr  <= if_addr;
                reqQ.wen   <= 1'b0;
                reqQ.wdata <= '0;
                reqQ.wdtOp <= WDT_DOUBLE;
                ownerLsu   <= 1'b0;
            end
            if (grantLsu && if_req_valid) begin
                if (starveCnt < CNT_WIDTH'(STARVE_LIMIT)) begin
                    starveCnt <= starveCnt + CNT_WIDTH'(1);
                end
            end else begin
                starveCnt <= '0;
            end
        end
    end

    assign mem_addr   = reqQ.addr;
    assign mem_wen    = reqQ.wen;
    assign mem_wdata  = reqQ.wdata;
    assign mem_wdt_op = reqQ.wdtOp;

endmodule
